wblock_sched: RTL and testbench

Block scheduler for the pixel weight-coding datapath. Runs in the pixel clock domain, tracks frame, line, and column position from vsync/hsync/de, and drives the accumulator controls (clear, enable, last). Publishes a tagged block-complete handshake to the downstream result consumer and flags malformed lines and result overruns. It holds no pixel data; the accumulator datapath sits beside it.

---
 rtl/wblock_sched.sv | 150 +++++++++++++++
 tb/tb_wblock_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wblock_sched.sv
// Block scheduler: tracks frame/line/column position from vsync/hsync/de and drives
// accumulator controls plus a tagged result handshake. WSCHED_FCNT_EN adds frame_cnt.
module wblock_sched #(
  parameter int COL_BLK = 4,
  parameter int BLKS    = 4,
  parameter int LINES   = 4
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic vsync,
  input  logic hsync,
  input  logic de,
  output logic acc_en,
  output logic acc_clr,
  output logic acc_last,
  output logic res_valid,
  input  logic res_ready,
  output logic [((BLKS  > 1) ? $clog2(BLKS)  : 1)-1:0] res_col,
  output logic [((LINES > 1) ? $clog2(LINES) : 1)-1:0] res_line,
  output logic frame_done,
  output logic line_err,
  output logic ovf
`ifdef WSCHED_FCNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int CW = $clog2(COL_BLK);
  localparam int BW = (BLKS  > 1) ? $clog2(BLKS)  : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COL_BLK - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLKS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, LINE_END} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [BW-1:0] blk;
  logic [LW-1:0] line;
  logic          vs_q, hs_q;
  logic          vs_e, hs_e;

  assign vs_e = vsync & ~vs_q;
  assign hs_e = hsync & ~hs_q;

  // Pixels coinciding with a sync edge are dropped so the accumulator never sees them.
  always_comb begin
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    if (state == ACTIVE && de && !vs_e && !hs_e) begin
      acc_en   = 1'b1;
      acc_clr  = (col == '0);
      acc_last = (col == COL_LAST);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      blk        <= '0;
      line       <= '0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      vs_q       <= vsync;
      hs_q       <= hsync;
      frame_done <= 1'b0;
      if (vs_e) begin
        state <= WAIT_LINE;
        line  <= '0;
        col   <= '0;
        blk   <= '0;
      end else begin
        case (state)
          IDLE: ;
          WAIT_LINE, LINE_END: begin
            if (hs_e) begin
              state <= ACTIVE;
              col   <= '0;
              blk   <= '0;
            end
          end
          ACTIVE: begin
            if (hs_e) begin
              // Short line: drop the partial block and move on to the next line.
              line_err <= 1'b1;
              col      <= '0;
              blk      <= '0;
              if (line == LINE_LAST) begin
                state <= IDLE;
                line  <= '0;
              end else begin
                line <= line + LW'(1);
              end
            end else if (acc_last) begin
              col <= '0;
              if (blk == BLK_LAST) begin
                blk <= '0;
                if (line == LINE_LAST) begin
                  state      <= IDLE;
                  line       <= '0;
                  frame_done <= 1'b1;
                end else begin
                  state <= LINE_END;
                  line  <= line + LW'(1);
                end
              end else begin
                blk <= blk + BW'(1);
              end
            end else if (acc_en) begin
              col <= col + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_col   <= '0;
      res_line  <= '0;
      ovf       <= 1'b0;
    end else if (acc_last) begin
      res_valid <= 1'b1;
      res_col   <= blk;
      res_line  <= line;
      if (res_valid && !res_ready) ovf <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef WSCHED_FCNT_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_wblock_sched.sv
// Directed testbench for wblock_sched at default parameters (4x4x4).
module tb_wblock_sched;

  logic       pclk = 1'b0;
  logic       rst_n, vsync, hsync, de, res_ready;
  logic       acc_en, acc_clr, acc_last, res_valid;
  logic [1:0] res_col, res_line;
  logic       frame_done, line_err, ovf;
`ifdef WSCHED_FCNT_EN
  logic [7:0] frame_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int fd_cnt = 0;
  logic [3:0] rq[$];

  wblock_sched #(.COL_BLK(4), .BLKS(4), .LINES(4)) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .hsync(hsync), .de(de),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_last(acc_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_col(res_col), .res_line(res_line),
    .frame_done(frame_done), .line_err(line_err), .ovf(ovf)
`ifdef WSCHED_FCNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  // Transfers and frame_done pulses, sampled mid-cycle.
  always @(negedge pclk) begin
    if (res_valid && res_ready) rq.push_back({res_line, res_col});
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
  endtask

  task automatic hs_pulse();
    hsync = 1'b1; tick(); hsync = 1'b0;
  endtask

  // n pixels starting at column index base; acc_* checked against the pixel position.
  task automatic pixels(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      #1;
      check("acc_en",   acc_en,   1);
      check("acc_clr",  acc_clr,  ((base + i) % 4) == 0);
      check("acc_last", acc_last, ((base + i) % 4) == 3);
      tick();
    end
    de = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    int fd0;
    rst_n = 1'b0; vsync = 1'b0; hsync = 1'b0; de = 1'b0; res_ready = 1'b1;
    tick(); tick();
    check("rst_acc_en", acc_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_tag", {res_line, res_col}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_line_err", line_err, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1; tick();

    // Full frame, consumer always ready.
    rq.delete();
    vs_pulse();
    for (int l = 0; l < 4; l++) begin
      hs_pulse();
      pixels(16, 0);
      if (l == 3) begin
        check("fd_pulse", frame_done, 1);
        tick();
        check("fd_one_cycle", frame_done, 0);
      end else begin
        de = 1'b1; #1;
        check("line_end_de_ignored", acc_en, 0);
        tick(); de = 1'b0;
      end
    end
    tick(); tick();
    check("ff_nres", rq.size(), 16);
    for (int i = 0; i < 16 && i < rq.size(); i++) check("ff_tag", rq[i], i);
    check("ff_fd_cnt", fd_cnt, 1);
    check("ff_line_err", line_err, 0);
    check("ff_ovf", ovf, 0);

    // Short line on line 0.
    rq.delete();
    vs_pulse();
    hs_pulse();
    pixels(6, 0);
    hs_pulse();
    check("short_line_err", line_err, 1);
    pixels(16, 0);
    tick(); tick();
    check("short_nres", rq.size(), 5);
    if (rq.size() >= 2) begin
      check("short_first", rq[0], 4'h0);
      check("short_next_line", rq[1], 4'h4);
    end

    // Overrun: two completions with no acceptance.
    do_reset();
    res_ready = 1'b0;
    vs_pulse();
    hs_pulse();
    pixels(4, 0);
    check("ovr_valid1", res_valid, 1);
    check("ovr_ovf0", ovf, 0);
    pixels(4, 4);
    check("ovr_ovf", ovf, 1);
    tick();
    check("ovr_valid2", res_valid, 1);
    check("ovr_tag", {res_line, res_col}, 4'h1);
    res_ready = 1'b1; tick();
    check("ovr_drain", res_valid, 0);

    // Mid-frame vsync during block 2 of line 1.
    do_reset();
    rq.delete();
    fd0 = fd_cnt;
    vs_pulse();
    hs_pulse(); pixels(16, 0);
    hs_pulse(); pixels(9, 0);
    vs_pulse();
    hs_pulse(); pixels(4, 0);
    tick(); tick();
    check("mvs_nres", rq.size(), 7);
    if (rq.size() == 7) begin
      check("mvs_before", rq[5], 4'h5);
      check("mvs_after", rq[6], 4'h0);
    end
    check("mvs_no_fd", fd_cnt - fd0, 0);

    // Asynchronous reset during line 2.
    do_reset();
    vs_pulse();
    hs_pulse(); pixels(16, 0);
    hs_pulse(); pixels(2, 0);
    hs_pulse(); pixels(4, 0);
    check("mrst_pre_valid", res_valid, 1);
    check("mrst_pre_tag", {res_line, res_col}, 4'h8);
    check("mrst_pre_err", line_err, 1);
    de = 1'b1; #1;
    check("mrst_pre_acc", acc_en, 1);
    rst_n = 1'b0; #1;
    check("mrst_acc_en", acc_en, 0);
    check("mrst_acc_clr", acc_clr, 0);
    check("mrst_valid", res_valid, 0);
    check("mrst_err", line_err, 0);
    check("mrst_tag", {res_line, res_col}, 0);
    tick(); rst_n = 1'b1; de = 1'b0; tick();
    hsync = 1'b1; de = 1'b1; tick(); hsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; check("mrst_wait_vs", acc_en, 0); tick();
    end
    de = 1'b0;
    vs_pulse(); hs_pulse(); pixels(4, 0);

`ifdef WSCHED_FCNT_EN
    do_reset();
    check("fcnt_rst", frame_cnt, 0);
    for (int f = 0; f < 2; f++) begin
      vs_pulse();
      for (int l = 0; l < 4; l++) begin hs_pulse(); pixels(16, 0); end
      tick();
    end
    vs_pulse(); hs_pulse(); pixels(5, 0); vs_pulse();
    tick(); tick();
    check("fcnt", frame_cnt, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
